// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 key controller.
//   ps2_state_t : decoder FSM states
//   PREFIX_EXT  : extended-key prefix byte (E0)
//   PREFIX_BRK  : break (key release) prefix byte (F0)
//   ps2_evt_t   : 10-bit key event record {ext, brk, code}
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_E0   = 3'd1,
        GOT_F0   = 3'd2,
        GOT_E0F0 = 3'd3,
        RECOVER  = 3'd4
    } ps2_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic ps2_evt_t make_evt(input logic ext, input logic brk,
                                          input logic [7:0] code);
        ps2_evt_t e;
        e.ext  = ext;
        e.brk  = brk;
        e.code = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo -- synchronous show-ahead FIFO of key events.
//   clk, srst  : clock and synchronous active-high reset
//   push       : write request; accepted when not full, or when full and a pop
//                happens in the same cycle
//   push_data  : event to write
//   pop        : read request; ignored when empty
//   head_data  : oldest stored event (zero when empty)
//   empty/full : occupancy flags
//   count      : number of stored events
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  ps2_evt_t                 push_data,
    input  logic                     pop,
    output ps2_evt_t                 head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ps2_evt_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Gate the head so the outputs read zero whenever nothing is stored.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// ps2_key_controller -- turns PS/2 scan bytes into make/break key events.
//   slowClk     : single clock, rising edge
//   reset       : synchronous active-high reset
//   rxValid     : one-cycle byte strobe from the receiver
//   rxByte      : received scan byte
//   rxError     : receiver sticky parity error
//   rxReset     : one-cycle pulse that clears the receiver
//   evtValid    : event FIFO head is valid
//   evtCode     : head event final scan byte
//   evtBreak    : head event is a key release
//   evtExtended : head event began with E0
//   evtReady    : consumer accept (pop on evtValid & evtReady)
//   overflow    : sticky, an event was dropped because the FIFO was full
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       slowClk,
    input  logic       reset,
    input  logic       rxValid,
    input  logic [7:0] rxByte,
    input  logic       rxError,
    output logic       rxReset,
    output logic       evtValid,
    output logic [7:0] evtCode,
    output logic       evtBreak,
    output logic       evtExtended,
    input  logic       evtReady,
    output logic       overflow
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    ps2_state_t       state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             rx_reset_q, rx_reset_d;
    logic             overflow_q, overflow_d;

    logic             push;
    ps2_evt_t         push_evt;
    logic             pop_req;
    ps2_evt_t         head_evt;
    logic             fifo_empty, fifo_full;
    logic [FCW-1:0]   fifo_count;

    assign pop_req = evtReady & ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        rx_reset_d = 1'b0;
        push       = 1'b0;
        push_evt   = '0;
        case (state_q)
            RECOVER: begin
                // Single settling cycle while the receiver clears; bytes ignored.
                state_d = IDLE;
                tmo_d   = '0;
            end
            default: begin
                if (rxError) begin
                    // Error wins over a same-cycle byte; any prefix is discarded.
                    state_d    = RECOVER;
                    rx_reset_d = 1'b1;
                    tmo_d      = '0;
                end else if (rxValid) begin
                    tmo_d = '0;
                    case (state_q)
                        IDLE: begin
                            if (rxByte == PREFIX_EXT)      state_d = GOT_E0;
                            else if (rxByte == PREFIX_BRK) state_d = GOT_F0;
                            else begin
                                push     = 1'b1;
                                push_evt = make_evt(1'b0, 1'b0, rxByte);
                            end
                        end
                        GOT_E0: begin
                            if (rxByte == PREFIX_BRK)      state_d = GOT_E0F0;
                            else if (rxByte != PREFIX_EXT) begin
                                push     = 1'b1;
                                push_evt = make_evt(1'b1, 1'b0, rxByte);
                                state_d  = IDLE;
                            end
                        end
                        GOT_F0: begin
                            if (rxByte != PREFIX_EXT && rxByte != PREFIX_BRK) begin
                                push     = 1'b1;
                                push_evt = make_evt(1'b0, 1'b1, rxByte);
                                state_d  = IDLE;
                            end
                        end
                        GOT_E0F0: begin
                            if (rxByte != PREFIX_EXT && rxByte != PREFIX_BRK) begin
                                push     = 1'b1;
                                push_evt = make_evt(1'b1, 1'b1, rxByte);
                                state_d  = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end else if (state_q != IDLE) begin
                    // Abandon a dangling prefix once the follow-up byte is overdue.
                    if (tmo_q == TIMEOUT_LAST) begin
                        state_d = IDLE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + CNT_W'(1);
                    end
                end
            end
        endcase
        overflow_d = overflow_q | (push & fifo_full & ~pop_req);
    end

    always_ff @(posedge slowClk) begin
        if (reset) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            rx_reset_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            rx_reset_q <= rx_reset_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (slowClk),
        .srst      (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop_req),
        .head_data (head_evt),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign evtValid    = (fifo_count != '0);
    assign evtCode     = head_evt.code;
    assign evtBreak    = head_evt.brk;
    assign evtExtended = head_evt.ext;
    assign rxReset     = rx_reset_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/ps2_key_controller.md
PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000, SHALL set the slowClk cycles allowed between prefix byte and following byte.
REQ-003 slowClk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rxValid  input  1  SHALL be the one-cycle byte-received strobe from the PS/2 receiver.
REQ-006 rxByte  input  8  SHALL be the received scan byte, valid while rxValid=1.
REQ-007 rxError  input  1  SHALL be the receiver's sticky parity-error flag.
REQ-008 rxReset  output  1  SHALL be a one-cycle pulse that clears the receiver.
REQ-009 evtValid  output  1  SHALL indicate the FIFO head holds an event.
REQ-010 evtCode  output  8  SHALL be the head event's final scan byte.
REQ-011 evtBreak  output  1  SHALL be 1 for key release (F0 seen), 0 for press.
REQ-012 evtExtended  output  1  SHALL be 1 when the sequence began with E0.
REQ-013 evtReady  input  1  SHALL be the consumer accept; pop occurs when evtValid&evtReady.
REQ-014 overflow  output  1  SHALL be a sticky flag: event dropped because FIFO full.

Function
REQ-015 FSM states SHALL be IDLE, GOT_E0, GOT_F0, GOT_E0F0, RECOVER.
REQ-016 IDLE: rxValid with E0 -> GOT_E0; F0 -> GOT_F0; any other byte -> push {ext=0,brk=0,code}, stay IDLE.
REQ-017 GOT_E0: F0 -> GOT_E0F0; E0 -> stay GOT_E0; other -> push {1,0,code}, IDLE.
REQ-018 GOT_F0: F0 or E0 -> stay GOT_F0; other -> push {0,1,code}, IDLE.
REQ-019 GOT_E0F0: E0 or F0 -> stay GOT_E0F0; other -> push {1,1,code}, IDLE.
REQ-020 Timeout counter SHALL clear on every rxValid and on entry to IDLE; in a GOT_* state reaching TIMEOUT_CYCLES-1 SHALL return to IDLE with no push.
REQ-021 rxError=1 in any non-RECOVER state SHALL take priority over rxValid: go RECOVER, discard prefix, pulse rxReset in the same cycle as entry.
REQ-022 RECOVER SHALL last exactly one cycle, ignore rxValid, then go IDLE; FIFO contents retained.
REQ-023 Pushed event SHALL appear on evt* the cycle after the completing rxValid when FIFO empty (latency 1).
REQ-024 evt* SHALL hold stable while evtValid=1 and evtReady=0.
REQ-025 Push when full and no pop SHALL drop the event and set overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-026 Push and pop in the same cycle when one entry is stored SHALL leave one entry (the new event).
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-028 reset=1 SHALL force state IDLE, FIFO empty, timeout counter 0, evtValid=0, evtCode=0, evtBreak=0, evtExtended=0, overflow=0, rxReset=0.
REQ-029 reset mid-sequence or mid-FIFO SHALL discard all pending prefix and events; no event emitted afterward from pre-reset bytes.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum, constants PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, and the 10-bit event record {ext,brk,code}.
REQ-031 FIFO SHALL be a sub-module ps2_event_fifo (synchronous, show-ahead, full/empty/count outputs); FSM and timeout stay in the top.

Verification
REQ-032 Bytes 1C; F0,1C (evtReady=1) -> events {0,0,1C} then {0,1,1C}, one cycle after each final byte.
REQ-033 Bytes E0,F0,75 -> single event {1,1,75}; E0,E0,74 -> {1,0,74}.
REQ-034 evtReady=0, FIFO_DEPTH=4, five make codes 15,16,17,18,19 -> four held in order 15..18, 19 dropped, overflow=1; overflow stays 1 after draining.
REQ-035 F0 then no byte for TIMEOUT_CYCLES cycles, then 1C -> event {0,0,1C} (no break).
REQ-036 E0 received, then rxError=1 with rxValid=1 same cycle -> rxReset one-cycle pulse, no push, next 1C -> {0,0,1C}.
REQ-037 FIFO full with evtReady=1 and completing byte 2A in same cycle -> pop and push both occur, count stays 4, overflow stays 0.
